rf_wb_scheduler: RTL and testbench

Register-file writeback scheduler and hazard scoreboard for the kant-v core. It shares the register file's single write port between several writeback sources using round-robin arbitration and drives registered write signals into the register file. It also keeps one busy bit per architectural register, and stalls instruction issue on RAW and WAW hazards until the pending write has landed and is readable.

---
 rtl/rf_wb_scheduler_if.sv | 44 ++++
 rtl/rf_wb_scheduler.sv | 132 +++++++++++++
 tb/tb_rf_wb_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - issue, writeback and register-file write bundle for rf_wb_scheduler
//
// Purpose: groups the decode issue handshake, the NUM_WB writeback request
// buses and the registered register-file write port into one interface.
// Ports (slave = scheduler side):
//   issue_valid/rs1/rs2/rd/uses_rs1/uses_rs2/writes_rd in, issue_ready out
//   wb_valid[NUM_WB], wb_rd[5*NUM_WB], wb_data[XLEN*NUM_WB] in, wb_grant[NUM_WB] out
//   rf_we, rf_rd[5], rf_wdata[XLEN], busy[32], wb_err out
interface rf_wb_scheduler_if #(
  parameter int NUM_WB = 3,
  parameter int XLEN   = 32
);
  logic                     issue_valid;
  logic [4:0]               issue_rs1;
  logic [4:0]               issue_rs2;
  logic [4:0]               issue_rd;
  logic                     issue_uses_rs1;
  logic                     issue_uses_rs2;
  logic                     issue_writes_rd;
  logic                     issue_ready;
  logic [NUM_WB-1:0]        wb_valid;
  logic [5*NUM_WB-1:0]      wb_rd;
  logic [XLEN*NUM_WB-1:0]   wb_data;
  logic [NUM_WB-1:0]        wb_grant;
  logic                     rf_we;
  logic [4:0]               rf_rd;
  logic [XLEN-1:0]          rf_wdata;
  logic [31:0]              busy;
  logic                     wb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           wb_valid, wb_rd, wb_data,
    input  issue_ready, wb_grant, rf_we, rf_rd, rf_wdata, busy, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_uses_rs1, issue_uses_rs2, issue_writes_rd,
           wb_valid, wb_rd, wb_data,
    output issue_ready, wb_grant, rf_we, rf_rd, rf_wdata, busy, wb_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - register-file writeback arbiter and RAW/WAW hazard scoreboard
//
// Purpose: round-robin shares the single register-file write port between
// NUM_WB writeback requesters, registers the winning write, and keeps one
// busy bit per architectural register to stall issue on RAW/WAW hazards.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - rf_wb_scheduler_if.slave: issue handshake, writeback requests and
//          grants, registered rf_we/rf_rd/rf_wdata, busy scoreboard, wb_err
module rf_wb_scheduler #(
  parameter int NUM_WB = 3,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_scheduler_if.slave  bus
);

  logic [31:0]       busy_q;
  logic [31:0]       busy_next;
  logic [1:0]        ptr_q;
  logic              rf_we_q;
  logic [4:0]        rf_rd_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic              wb_err_q;

  logic              hazard;
  logic              issue_ready;
  logic              issue_sets_busy;

  logic [3:0]        valid4;
  logic [2:0]        sum;
  logic [1:0]        idx;
  logic [1:0]        gidx;
  logic              found;
  logic [NUM_WB-1:0] grant;
  logic              grant_any;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;

  // Hazard check only looks at registered busy bits, never at wb_* inputs.
  always_comb begin
    hazard = (bus.issue_uses_rs1  && busy_q[bus.issue_rs1]) ||
             (bus.issue_uses_rs2  && busy_q[bus.issue_rs2]) ||
             (bus.issue_writes_rd && busy_q[bus.issue_rd]);
    issue_ready     = rst && bus.issue_valid && !hazard;
    issue_sets_busy = issue_ready && bus.issue_writes_rd && (bus.issue_rd != 5'd0);
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    valid4 = 4'(bus.wb_valid);
    sum    = 3'd0;
    idx    = 2'd0;
    gidx   = 2'd0;
    found  = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      if (sum >= 3'(NUM_WB)) begin
        sum = sum - 3'(NUM_WB);
      end
      idx = sum[1:0];
      if (!found && valid4[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant     = (found && rst) ? NUM_WB'(4'b0001 << gidx) : '0;
    grant_any = |grant;
  end

  always_comb begin
    sel_rd   = 5'd0;
    sel_data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (grant[i]) begin
        sel_rd   = bus.wb_rd[5*i +: 5];
        sel_data = bus.wb_data[XLEN*i +: XLEN];
      end
    end
  end

  // Clear lands on the edge that ends the rf_we cycle; a same-index set in
  // that cycle is impossible because the WAW check blocks it.
  always_comb begin
    busy_next = busy_q;
    if (rf_we_q) begin
      busy_next[rf_rd_q] = 1'b0;
    end
    if (issue_sets_busy) begin
      busy_next[bus.issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q     <= '0;
      ptr_q      <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (grant_any) begin
        ptr_q <= (gidx == 2'(NUM_WB - 1)) ? 2'd0 : gidx + 2'd1;
        // A grant to x0 consumes the request but never writes.
        rf_we_q <= (sel_rd != 5'd0);
        if (sel_rd != 5'd0) begin
          rf_rd_q    <= sel_rd;
          rf_wdata_q <= sel_data;
          if (!busy_q[sel_rd]) begin
            wb_err_q <= 1'b1;
          end
        end
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.wb_grant    = grant;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.busy        = busy_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler
module tb_rf_wb_scheduler;
  localparam int N  = 3;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler_if #(.NUM_WB(N), .XLEN(XL)) bus ();
  rf_wb_scheduler #(.NUM_WB(N), .XLEN(XL)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid     = 1'b0;
    bus.issue_rs1       = 5'd0;
    bus.issue_rs2       = 5'd0;
    bus.issue_rd        = 5'd0;
    bus.issue_uses_rs1  = 1'b0;
    bus.issue_uses_rs2  = 1'b0;
    bus.issue_writes_rd = 1'b0;
    bus.wb_valid        = '0;
    bus.wb_rd           = '0;
    bus.wb_data         = '0;
  endtask

  task automatic set_wb(input int i, input logic v, input logic [4:0] rd, input logic [XL-1:0] d);
    bus.wb_valid[i]        = v;
    bus.wb_rd[5*i +: 5]    = rd;
    bus.wb_data[XL*i +: XL] = d;
  endtask

  task automatic set_issue(input logic v, input logic u1, input logic [4:0] r1,
                           input logic u2, input logic [4:0] r2,
                           input logic w, input logic [4:0] rd);
    bus.issue_valid     = v;
    bus.issue_uses_rs1  = u1;
    bus.issue_rs1       = r1;
    bus.issue_uses_rs2  = u2;
    bus.issue_rs2       = r2;
    bus.issue_writes_rd = w;
    bus.issue_rd        = rd;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    tests++; if (bus.busy !== 32'd0) begin fails++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
    tests++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'd0) begin
      fails++; $display("FAIL reset_rf: got we=%b rd=%0d wd=%h want 0/0/0", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.wb_err); end
    bus.issue_valid = 1'b1;
    bus.wb_valid    = '1;
    settle();
    tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_forced: got %b want 0", bus.issue_ready); end
    tests++; if (bus.wb_grant !== 3'b000) begin fails++; $display("FAIL reset_grant_forced: got %b want 000", bus.wb_grant); end
    clear_inputs();
    rst = 1'b1;
    tick();
    set_issue(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0);
    settle();
    tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", bus.issue_ready); end
    tests++; if (bus.wb_grant !== 3'b000) begin fails++; $display("FAIL idle_grant: got %b want 000", bus.wb_grant); end
    clear_inputs();
    tick();
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    settle();
    tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL raw_c0_ready: got %b want 1", bus.issue_ready); end
    tick();
    set_issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    settle();
    tests++; if (bus.busy !== 32'h0000_0020) begin fails++; $display("FAIL raw_c1_busy: got %h want 00000020", bus.busy); end
    tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c1_stall: got %b want 0", bus.issue_ready); end
    tick();
    tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c2_stall: got %b want 0", bus.issue_ready); end
    tick();
    set_wb(1, 1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    tests++; if (bus.wb_grant !== 3'b010) begin fails++; $display("FAIL raw_c3_grant: got %b want 010", bus.wb_grant); end
    tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c3_stall: got %b want 0", bus.issue_ready); end
    tick();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    settle();
    tests++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL raw_c4_write: got we=%b rd=%0d wd=%h want 1/5/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
    tests++; if (bus.issue_ready !== 1'b0) begin fails++; $display("FAIL raw_c4_stall: got %b want 0", bus.issue_ready); end
    tick();
    tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL raw_c5_ready: got %b want 1", bus.issue_ready); end
    tests++; if (bus.busy !== 32'd0 || bus.rf_we !== 1'b0) begin
      fails++; $display("FAIL raw_c5_state: got busy=%h we=%b want 0/0", bus.busy, bus.rf_we); end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rd [3];
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      set_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(r));
      tick();
    end
    clear_inputs();
    settle();
    tests++; if (bus.busy !== 32'h0000_000E) begin fails++; $display("FAIL rr_busy: got %h want 0000000e", bus.busy); end
    for (int i = 0; i < 3; i++) set_wb(i, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
    exp_rd = '{5'd1, 5'd2, 5'd3};
    for (int g = 0; g < 3; g++) begin
      settle();
      tests++; if (bus.wb_grant !== 3'(1 << g)) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", g, bus.wb_grant, 3'(1 << g)); end
      tick();
      set_wb(g, 1'b0, 5'd0, 32'd0);
      settle();
      tests++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== exp_rd[g] || bus.rf_wdata !== 32'hA000_0000 + 32'(g)) begin
        fails++; $display("FAIL rr_write%0d: got we=%b rd=%0d wd=%h want 1/%0d/%h", g, bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_rd[g], 32'hA000_0000 + 32'(g)); end
    end
    tick();
    tests++; if (bus.rf_we !== 1'b0 || bus.busy !== 32'd0 || bus.wb_err !== 1'b0) begin
      fails++; $display("FAIL rr_drain: got we=%b busy=%h err=%b want 0/0/0", bus.rf_we, bus.busy, bus.wb_err); end
  endtask

  task automatic test_x0();
    do_reset();
    set_issue(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    settle();
    tests++; if (bus.issue_ready !== 1'b1) begin fails++; $display("FAIL x0_ready: got %b want 1", bus.issue_ready); end
    tick();
    clear_inputs();
    settle();
    tests++; if (bus.busy !== 32'd0) begin fails++; $display("FAIL x0_busy: got %h want 0", bus.busy); end
    set_wb(0, 1'b1, 5'd0, 32'h5555_AAAA);
    settle();
    tests++; if (bus.wb_grant !== 3'b001) begin fails++; $display("FAIL x0_grant: got %b want 001", bus.wb_grant); end
    tick();
    clear_inputs();
    settle();
    tests++; if (bus.rf_we !== 1'b0 || bus.wb_err !== 1'b0) begin
      fails++; $display("FAIL x0_nowrite: got we=%b err=%b want 0/0", bus.rf_we, bus.wb_err); end
  endtask

  task automatic test_err();
    do_reset();
    set_wb(2, 1'b1, 5'd7, 32'h1234_5678);
    settle();
    tests++; if (bus.wb_grant !== 3'b100) begin fails++; $display("FAIL err_grant: got %b want 100", bus.wb_grant); end
    tick();
    clear_inputs();
    settle();
    tests++; if (bus.wb_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", bus.wb_err); end
    tests++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'h1234_5678) begin
      fails++; $display("FAIL err_write: got we=%b rd=%0d wd=%h want 1/7/12345678", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
    tick();
    tick();
    tests++; if (bus.wb_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", bus.wb_err); end
    do_reset();
    settle();
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", bus.wb_err); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    set_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    clear_inputs();
    set_wb(0, 1'b1, 5'd9, 32'hCAFE_F00D);
    settle();
    tests++; if (bus.wb_grant !== 3'b001) begin fails++; $display("FAIL midrst_grant: got %b want 001", bus.wb_grant); end
    rst = 1'b0;
    settle();
    tests++; if (bus.wb_grant !== 3'b000) begin fails++; $display("FAIL midrst_grant_forced: got %b want 000", bus.wb_grant); end
    tick();
    clear_inputs();
    settle();
    tests++; if (bus.rf_we !== 1'b0 || bus.busy !== 32'd0) begin
      fails++; $display("FAIL midrst_flush: got we=%b busy=%h want 0/0", bus.rf_we, bus.busy); end
    rst = 1'b1;
    tick();
    tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL midrst_after: got %b want 0", bus.rf_we); end
  endtask

  task automatic test_random();
    bit          mb [32];
    logic [4:0]  outstanding [$];
    bit          pv [N];
    logic [4:0]  prd [N];
    logic [31:0] pdata [N];
    int          mptr;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    int          g;
    bit          exp_ready;
    logic [N-1:0] exp_grant;
    logic [31:0] exp_busy;
    int          pick;

    do_reset();
    for (int r = 0; r < 32; r++) mb[r] = 1'b0;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; prd[i] = 5'd0; pdata[i] = 32'd0; end
    outstanding.delete();
    mptr = 0; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0;

    for (int cyc = 0; cyc < 500; cyc++) begin
      // Idle requesters take a new job: normally an outstanding register, sometimes x0.
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          if (outstanding.size() > 0) begin
            pick = $urandom_range(outstanding.size() - 1, 0);
            prd[i] = outstanding[pick];
            outstanding.delete(pick);
            pv[i] = 1'b1;
            pdata[i] = $urandom;
          end else if ($urandom_range(7, 0) == 0) begin
            prd[i] = 5'd0;
            pv[i] = 1'b1;
            pdata[i] = $urandom;
          end
        end
        set_wb(i, pv[i], pv[i] ? prd[i] : 5'($urandom_range(31, 0)), pv[i] ? pdata[i] : 32'($urandom));
      end
      set_issue($urandom_range(9, 0) < 7, 1'($urandom), 5'($urandom_range(7, 0)),
                1'($urandom), 5'($urandom_range(7, 0)), 1'($urandom), 5'($urandom_range(7, 0)));

      exp_ready = bus.issue_valid &&
                  !(bus.issue_uses_rs1  && mb[bus.issue_rs1]) &&
                  !(bus.issue_uses_rs2  && mb[bus.issue_rs2]) &&
                  !(bus.issue_writes_rd && mb[bus.issue_rd]);
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pv[(mptr + k) % N]) g = (mptr + k) % N;
      end
      exp_grant = (g >= 0) ? N'(1 << g) : '0;

      settle();
      tests++; if (bus.issue_ready !== exp_ready) begin
        fails++; $display("FAIL rand_ready c%0d: got %b want %b", cyc, bus.issue_ready, exp_ready); end
      tests++; if (bus.wb_grant !== exp_grant) begin
        fails++; $display("FAIL rand_grant c%0d: got %b want %b", cyc, bus.wb_grant, exp_grant); end

      tick();

      if (m_we) mb[m_rd] = 1'b0;
      if (exp_ready && bus.issue_writes_rd && bus.issue_rd != 5'd0) begin
        mb[bus.issue_rd] = 1'b1;
        outstanding.push_back(bus.issue_rd);
      end
      if (g >= 0) begin
        m_we = (prd[g] != 5'd0);
        if (prd[g] != 5'd0) begin
          m_rd = prd[g];
          m_wd = pdata[g];
        end
        pv[g] = 1'b0;
        mptr = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end

      exp_busy = 32'd0;
      for (int r = 1; r < 32; r++) exp_busy[r] = mb[r];
      tests++; if (bus.busy !== exp_busy) begin
        fails++; $display("FAIL rand_busy c%0d: got %h want %h", cyc, bus.busy, exp_busy); end
      tests++; if (bus.rf_we !== m_we) begin
        fails++; $display("FAIL rand_we c%0d: got %b want %b", cyc, bus.rf_we, m_we); end
      if (m_we) begin
        tests++; if (bus.rf_rd !== m_rd || bus.rf_wdata !== m_wd) begin
          fails++; $display("FAIL rand_write c%0d: got rd=%0d wd=%h want %0d/%h", cyc, bus.rf_rd, bus.rf_wdata, m_rd, m_wd); end
      end
      tests++; if (bus.wb_err !== 1'b0) begin
        fails++; $display("FAIL rand_err c%0d: got %b want 0", cyc, bus.wb_err); end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_x0();
    test_err();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
